exec_unit: RTL and testbench

- Execute stage directly downstream of the instruction control unit.
- Consumes its one-hot operation strobes, operand address and execute qualifier, and owns the architectural AC, E and PC registers.
- Performs memory-reference operations through a req/ack memory port and register-reference operations locally.
- Returns a one-cycle ex_done pulse that advances the control FSM.

---
 rtl/exec_unit_pkg.sv | 44 ++++
 rtl/exec_alu.sv | 43 ++++
 rtl/exec_unit.sv | 170 +++++++++++++++++
 tb/tb_exec_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// Shared encodings for the execute stage: FSM states, op indices, width defaults.
// Op indices double as bit positions of the one-hot strobe vector; a lower index wins.
package exec_unit_pkg;

  localparam int DWIDTH_DEF    = 16;
  localparam int AWIDTH_DEF    = 12;
  localparam int IMM_WIDTH_DEF = 8;
  localparam int NUM_OPS       = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM_RD = 3'd1,
    ST_ALU    = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_LOAD    = 4'd1,
    OP_STORE   = 4'd2,
    OP_BRANCH  = 4'd3,
    OP_ISZ     = 4'd4,
    OP_CLR_AC  = 4'd5,
    OP_CLR_E   = 4'd6,
    OP_COMP_AC = 4'd7,
    OP_LOAD_AC = 4'd8,
    OP_CIR_R   = 4'd9,
    OP_CIR_L   = 4'd10,
    OP_INC_AC  = 4'd11,
    OP_NOP     = 4'd15
  } op_t;

  // Scan from the lowest-priority strobe up so the highest-priority one lands last.
  function automatic op_t op_encode(input logic [NUM_OPS-1:0] s);
    op_t r;
    r = OP_NOP;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (s[i]) r = op_t'(i[3:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational datapath for the execute stage: add with carry, increment, rotate, complement.
// Zero latency, no flow control; b carries the memory operand or the zero-extended immediate.
module exec_alu
  import exec_unit_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  op_t               op,
  input  logic [DWIDTH-1:0] ac,
  input  logic              e,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] y,
  output logic              e_out
);

  logic [DWIDTH:0] sum;

  assign sum = {1'b0, ac} + {1'b0, b};

  always_comb begin
    y     = ac;
    e_out = e;
    case (op)
      OP_ADD:              {e_out, y} = sum;
      OP_LOAD, OP_LOAD_AC: y = b;
      OP_ISZ:              y = b + DWIDTH'(1);
      OP_CLR_AC:           y = '0;
      OP_CLR_E:            e_out = 1'b0;
      OP_COMP_AC:          y = ~ac;
      OP_CIR_R: begin
        y     = {e, ac[DWIDTH-1:1]};
        e_out = ac[0];
      end
      OP_CIR_L: begin
        y     = {ac[DWIDTH-2:0], e};
        e_out = ac[DWIDTH-1];
      end
      OP_INC_AC:           y = ac + DWIDTH'(1);
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage owning AC/E/PC: register ops finish one cycle after i_execute, memory ops
// hold req/we/addr/wdata stable until a one-cycle ack; i_execute is ignored while busy.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int AWIDTH    = AWIDTH_DEF,
  parameter int IMM_WIDTH = IMM_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_execute,
  input  logic [AWIDTH-1:0]    i_addr,
  input  logic [IMM_WIDTH-1:0] i_imm,
  input  logic                 i_add,
  input  logic                 i_load,
  input  logic                 i_store,
  input  logic                 i_branch,
  input  logic                 i_isz,
  input  logic                 i_clr_ac,
  input  logic                 i_clr_e,
  input  logic                 i_comp_ac,
  input  logic                 i_load_ac,
  input  logic                 i_cir_r,
  input  logic                 i_cir_l,
  input  logic                 i_inc_ac,
  input  logic                 i_pc_inc,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [AWIDTH-1:0]    o_mem_addr,
  output logic [DWIDTH-1:0]    o_mem_wdata,
  input  logic [DWIDTH-1:0]    i_mem_rdata,
  input  logic                 i_mem_ack,
  output logic [DWIDTH-1:0]    o_ac,
  output logic                 o_e,
  output logic [AWIDTH-1:0]    o_pc,
  output logic                 o_ex_done,
  output logic                 o_busy
);

  state_t              state;
  op_t                 op_q;
  op_t                 op_start;
  op_t                 alu_op;
  logic [NUM_OPS-1:0]  strobes;
  logic [DWIDTH-1:0]   ac_q;
  logic                e_q;
  logic [AWIDTH-1:0]   pc_q;
  logic [DWIDTH-1:0]   operand_q;
  logic [DWIDTH-1:0]   imm_ext;
  logic [DWIDTH-1:0]   alu_b;
  logic [DWIDTH-1:0]   alu_y;
  logic                alu_e;

  assign strobes = {i_inc_ac, i_cir_l, i_cir_r, i_load_ac, i_comp_ac, i_clr_e,
                    i_clr_ac, i_isz, i_branch, i_store, i_load, i_add};
  assign op_start = op_encode(strobes);
  assign imm_ext  = {{(DWIDTH-IMM_WIDTH){1'b0}}, i_imm};

  // The ALU serves the start edge in IDLE and the latched op in the ALU state.
  always_comb begin
    alu_op = op_start;
    alu_b  = imm_ext;
    if (state == ST_ALU) begin
      alu_op = op_q;
      alu_b  = operand_q;
    end
  end

  exec_alu #(.DWIDTH(DWIDTH)) u_alu (
    .op    (alu_op),
    .ac    (ac_q),
    .e     (e_q),
    .b     (alu_b),
    .y     (alu_y),
    .e_out (alu_e)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      op_q        <= OP_NOP;
      ac_q        <= '0;
      e_q         <= 1'b0;
      pc_q        <= '0;
      operand_q   <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_ex_done   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_ex_done <= 1'b0;
      if (i_pc_inc) pc_q <= pc_q + AWIDTH'(1);
      case (state)
        ST_IDLE: begin
          if (i_execute) begin
            op_q       <= op_start;
            o_mem_addr <= i_addr;
            o_busy     <= 1'b1;
            state      <= ST_DONE;
            o_ex_done  <= 1'b1;
            case (op_start)
              OP_ADD, OP_LOAD, OP_ISZ: begin
                state     <= ST_MEM_RD;
                o_ex_done <= 1'b0;
                o_mem_req <= 1'b1;
                o_mem_we  <= 1'b0;
              end
              OP_STORE: begin
                state       <= ST_MEM_WR;
                o_ex_done   <= 1'b0;
                o_mem_req   <= 1'b1;
                o_mem_we    <= 1'b1;
                o_mem_wdata <= ac_q;
              end
              OP_BRANCH: pc_q <= i_addr;
              OP_NOP: ;
              default: begin
                ac_q <= alu_y;
                e_q  <= alu_e;
              end
            endcase
          end
        end
        ST_MEM_RD: begin
          if (i_mem_ack) begin
            operand_q <= i_mem_rdata;
            o_mem_req <= 1'b0;
            state     <= ST_ALU;
          end
        end
        ST_ALU: begin
          if (op_q == OP_ISZ) begin
            o_mem_wdata <= alu_y;
            o_mem_req   <= 1'b1;
            o_mem_we    <= 1'b1;
            state       <= ST_MEM_WR;
            // Skip stacks with a same-cycle fetch increment: PC+2.
            if (alu_y == '0) pc_q <= pc_q + {{(AWIDTH-2){1'b0}}, i_pc_inc, ~i_pc_inc};
          end else begin
            ac_q      <= alu_y;
            e_q       <= alu_e;
            state     <= ST_DONE;
            o_ex_done <= 1'b1;
          end
        end
        ST_MEM_WR: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            state     <= ST_DONE;
            o_ex_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ac = ac_q;
  assign o_e  = e_q;
  assign o_pc = pc_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: table of register/branch ops plus hand-written memory sequences.
module tb_exec_unit;

  localparam logic [11:0] S_ADD     = 12'h001;
  localparam logic [11:0] S_LOAD    = 12'h002;
  localparam logic [11:0] S_STORE   = 12'h004;
  localparam logic [11:0] S_BRANCH  = 12'h008;
  localparam logic [11:0] S_ISZ     = 12'h010;
  localparam logic [11:0] S_CLR_AC  = 12'h020;
  localparam logic [11:0] S_CLR_E   = 12'h040;
  localparam logic [11:0] S_COMP    = 12'h080;
  localparam logic [11:0] S_LOAD_AC = 12'h100;
  localparam logic [11:0] S_CIR_R   = 12'h200;
  localparam logic [11:0] S_CIR_L   = 12'h400;
  localparam logic [11:0] S_INC     = 12'h800;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_execute = 1'b0;
  logic [11:0] i_addr = '0;
  logic [7:0]  i_imm = '0;
  logic        i_add = 0, i_load = 0, i_store = 0, i_branch = 0, i_isz = 0;
  logic        i_clr_ac = 0, i_clr_e = 0, i_comp_ac = 0, i_load_ac = 0;
  logic        i_cir_r = 0, i_cir_l = 0, i_inc_ac = 0, i_pc_inc = 0;
  logic        o_mem_req, o_mem_we;
  logic [11:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata = '0;
  logic        i_mem_ack = 1'b0;
  logic [15:0] o_ac;
  logic        o_e;
  logic [11:0] o_pc;
  logic        o_ex_done, o_busy;

  int checks = 0;
  int passes = 0;
  int req_cyc, lat;
  logic        wr_seen, addr_bad;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;

  typedef struct {
    logic [11:0] s;
    logic [7:0]  imm;
    logic [11:0] addr;
    logic [15:0] ac;
    logic        e;
    logic [11:0] pc;
  } vec_t;

  vec_t vecs[18];

  exec_unit dut (
    .clk(clk), .reset(reset), .i_execute(i_execute), .i_addr(i_addr), .i_imm(i_imm),
    .i_add(i_add), .i_load(i_load), .i_store(i_store), .i_branch(i_branch), .i_isz(i_isz),
    .i_clr_ac(i_clr_ac), .i_clr_e(i_clr_e), .i_comp_ac(i_comp_ac), .i_load_ac(i_load_ac),
    .i_cir_r(i_cir_r), .i_cir_l(i_cir_l), .i_inc_ac(i_inc_ac), .i_pc_inc(i_pc_inc),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_ac(o_ac), .o_e(o_e), .o_pc(o_pc), .o_ex_done(o_ex_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_strobes(input logic [11:0] s);
    {i_inc_ac, i_cir_l, i_cir_r, i_load_ac, i_comp_ac, i_clr_e,
     i_clr_ac, i_isz, i_branch, i_store, i_load, i_add} = s;
  endtask

  // Pulses i_execute, answers memory requests after ack_dly idle req cycles,
  // and measures latency (in cycles from the start edge) to ex_done.
  task automatic run_op(input logic [11:0] s, input logic [11:0] addr, input logic [7:0] imm,
                        input int ack_dly, input logic [15:0] rdata);
    int   wait_c;
    logic got;
    @(negedge clk);
    set_strobes(s);
    i_addr    = addr;
    i_imm     = imm;
    i_execute = 1'b1;
    @(negedge clk);
    set_strobes('0);
    i_execute = 1'b0;
    chk("busy_running", o_busy, 1);
    req_cyc = 0; lat = 1; wr_seen = 0; addr_bad = 0; wait_c = 0; got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (o_ex_done) got = 1'b1;
      else begin
        if (o_mem_req) begin
          req_cyc++;
          if (o_mem_addr !== addr) addr_bad = 1'b1;
          if (wait_c == ack_dly) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = rdata;
            wait_c      = 0;
            if (o_mem_we) begin
              wr_seen = 1'b1;
              wr_addr = o_mem_addr;
              wr_data = o_mem_wdata;
            end
          end else wait_c++;
        end
        @(negedge clk);
        i_mem_ack = 1'b0;
        lat++;
      end
    end
    chk("ex_done_seen", got, 1);
    @(negedge clk);
    chk("ex_done_single", o_ex_done, 0);
    chk("idle_after_done", o_busy, 0);
  endtask

  initial begin
    vecs[0]  = '{S_LOAD_AC,          8'h5A, 12'h000, 16'h005A, 1'b0, 12'h000};
    vecs[1]  = '{S_COMP,             8'h00, 12'h000, 16'hFFA5, 1'b0, 12'h000};
    vecs[2]  = '{S_INC,              8'h00, 12'h000, 16'hFFA6, 1'b0, 12'h000};
    vecs[3]  = '{S_LOAD_AC,          8'hFF, 12'h000, 16'h00FF, 1'b0, 12'h000};
    vecs[4]  = '{S_CIR_L,            8'h00, 12'h000, 16'h01FE, 1'b0, 12'h000};
    vecs[5]  = '{S_CIR_R,            8'h00, 12'h000, 16'h00FF, 1'b0, 12'h000};
    vecs[6]  = '{S_CIR_R,            8'h00, 12'h000, 16'h007F, 1'b1, 12'h000};
    vecs[7]  = '{S_CLR_E,            8'h00, 12'h000, 16'h007F, 1'b0, 12'h000};
    vecs[8]  = '{S_COMP,             8'h00, 12'h000, 16'hFF80, 1'b0, 12'h000};
    vecs[9]  = '{S_CIR_L,            8'h00, 12'h000, 16'hFF00, 1'b1, 12'h000};
    vecs[10] = '{S_CLR_AC,           8'h00, 12'h000, 16'h0000, 1'b1, 12'h000};
    vecs[11] = '{S_COMP,             8'h00, 12'h000, 16'hFFFF, 1'b1, 12'h000};
    vecs[12] = '{S_INC,              8'h00, 12'h000, 16'h0000, 1'b1, 12'h000};
    vecs[13] = '{S_BRANCH,           8'h00, 12'h0AB, 16'h0000, 1'b1, 12'h0AB};
    vecs[14] = '{12'h000,            8'h00, 12'h000, 16'h0000, 1'b1, 12'h0AB};
    vecs[15] = '{S_COMP | S_LOAD_AC, 8'h12, 12'h000, 16'hFFFF, 1'b1, 12'h0AB};
    vecs[16] = '{S_LOAD_AC | S_CIR_R,8'h12, 12'h000, 16'h0012, 1'b1, 12'h0AB};
    vecs[17] = '{S_CLR_E | S_COMP,   8'h00, 12'h000, 16'h0012, 1'b0, 12'h0AB};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ac", o_ac, 0);
    chk("rst_e", o_e, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_req", o_mem_req, 0);
    chk("rst_we", o_mem_we, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_done", o_ex_done, 0);
    chk("rst_busy", o_busy, 0);

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].s, vecs[i].addr, vecs[i].imm, 0, 16'h0000);
      chk($sformatf("vec%0d_lat", i), lat, 1);
      chk($sformatf("vec%0d_req", i), req_cyc, 0);
      chk($sformatf("vec%0d_ac", i), o_ac, vecs[i].ac);
      chk($sformatf("vec%0d_e", i), o_e, vecs[i].e);
      chk($sformatf("vec%0d_pc", i), o_pc, vecs[i].pc);
    end

    // Fetch-side increments, wrap, and branch priority.
    @(negedge clk); i_pc_inc = 1'b1;
    @(negedge clk); i_pc_inc = 1'b0;
    chk("pc_inc", o_pc, 12'h0AC);
    run_op(S_BRANCH, 12'hFFF, 8'h00, 0, 16'h0000);
    @(negedge clk); i_pc_inc = 1'b1;
    @(negedge clk); i_pc_inc = 1'b0;
    chk("pc_inc_wrap", o_pc, 12'h000);
    @(negedge clk);
    set_strobes(S_BRANCH); i_addr = 12'h123; i_execute = 1'b1; i_pc_inc = 1'b1;
    @(negedge clk);
    set_strobes('0); i_execute = 1'b0; i_pc_inc = 1'b0;
    chk("branch_beats_inc", o_pc, 12'h123);
    chk("branch_done", o_ex_done, 1);

    // add with 0x7FFF + 1, ack in the third request cycle.
    run_op(S_LOAD, 12'h030, 8'h00, 1, 16'h7FFF);
    chk("load_ac", o_ac, 16'h7FFF);
    chk("load_lat", lat, 4);
    run_op(S_ADD, 12'h010, 8'h00, 2, 16'h0001);
    chk("add1_ac", o_ac, 16'h8000);
    chk("add1_e", o_e, 0);
    chk("add1_req_cycles", req_cyc, 3);
    chk("add1_lat", lat, 5);
    chk("add1_addr_stable", addr_bad, 0);

    // Zero-wait add producing a carry.
    run_op(S_LOAD, 12'h031, 8'h00, 0, 16'hFFFF);
    run_op(S_ADD, 12'h011, 8'h00, 0, 16'h0002);
    chk("add2_ac", o_ac, 16'h0001);
    chk("add2_e", o_e, 1);
    chk("add2_lat", lat, 3);

    run_op(S_CIR_R, 12'h000, 8'h00, 0, 16'h0000);
    chk("cir_r_ac", o_ac, 16'h8000);
    chk("cir_r_e", o_e, 1);
    chk("cir_r_lat", lat, 1);
    run_op(S_CIR_L, 12'h000, 8'h00, 0, 16'h0000);
    chk("cir_l_ac", o_ac, 16'h0001);
    chk("cir_l_e", o_e, 1);
    chk("cir_l_lat", lat, 1);

    // isz wrapping to zero skips; non-zero result does not.
    run_op(S_BRANCH, 12'h005, 8'h00, 0, 16'h0000);
    run_op(S_ISZ, 12'h020, 8'h00, 0, 16'hFFFF);
    chk("isz_wr_seen", wr_seen, 1);
    chk("isz_wr_addr", wr_addr, 12'h020);
    chk("isz_wr_data", wr_data, 16'h0000);
    chk("isz_pc_skip", o_pc, 12'h006);
    chk("isz_ac_kept", o_ac, 16'h0001);
    chk("isz_lat", lat, 4);
    run_op(S_ISZ, 12'h021, 8'h00, 0, 16'h0041);
    chk("isz2_wr_data", wr_data, 16'h0042);
    chk("isz2_pc", o_pc, 12'h006);

    // add beats clr_ac when both strobes are set.
    run_op(S_ADD | S_CLR_AC, 12'h040, 8'h00, 0, 16'h1234);
    chk("prio_ac", o_ac, 16'h1235);
    chk("prio_e", o_e, 0);
    chk("prio_req", req_cyc, 1);

    // Normal store, then a store aborted by reset.
    run_op(S_LOAD, 12'h032, 8'h00, 0, 16'hA5A5);
    run_op(S_STORE, 12'h0FE, 8'h00, 1, 16'h0000);
    chk("st_wr_addr", wr_addr, 12'h0FE);
    chk("st_wr_data", wr_data, 16'hA5A5);
    chk("st_lat", lat, 3);
    @(negedge clk);
    set_strobes(S_STORE); i_addr = 12'h0FF; i_execute = 1'b1;
    @(negedge clk);
    set_strobes('0); i_execute = 1'b0;
    chk("st2_req", o_mem_req, 1);
    chk("st2_we", o_mem_we, 1);
    chk("st2_addr", o_mem_addr, 12'h0FF);
    chk("st2_wdata", o_mem_wdata, 16'hA5A5);
    @(negedge clk);
    chk("st2_req_held", o_mem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req", o_mem_req, 0);
    chk("abort_ac", o_ac, 0);
    chk("abort_pc", o_pc, 0);
    chk("abort_busy", o_busy, 0);
    i_mem_ack = 1'b1;
    @(negedge clk);
    i_mem_ack = 1'b0;
    chk("late_ack_done", o_ex_done, 0);
    chk("late_ack_req", o_mem_req, 0);
    chk("late_ack_busy", o_busy, 0);
    @(negedge clk);
    chk("late_ack_done2", o_ex_done, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
